// File: rtl/lzd_8.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lzd_8 : registered leading-zero detector built as a 2-bit LZD merge tree |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lzd_8 #(
  parameter int LZD_BITS = 32,
  parameter int P_BITS   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LZD_BITS-1:0] a,
  output logic [P_BITS-1:0]   p,
  output logic                v
);

  logic              w_v_top;
  logic [P_BITS-1:0] w_p_top;

  // Level l holds LZD_BITS>>l nodes, each with an l-bit count packed at [n*l +: l].
  for (genvar l = 1; l <= P_BITS; l++) begin : g_lvl
    localparam int NODES = LZD_BITS >> l;
    logic [NODES-1:0]   w_v;
    logic [NODES*l-1:0] w_p;

    if (l == 1) begin : g_leaf
      for (genvar n = 0; n < NODES; n++) begin : g_cell
        assign w_v[n] = a[2*n+1] | a[2*n];
        assign w_p[n] = ~a[2*n+1];
      end
    end else begin : g_merge
      for (genvar n = 0; n < NODES; n++) begin : g_cell
        logic         w_vh;
        logic         w_vl;
        logic [l-2:0] w_ph;
        logic [l-2:0] w_pl;
        assign w_vh = g_lvl[l-1].w_v[2*n+1];
        assign w_vl = g_lvl[l-1].w_v[2*n];
        assign w_ph = g_lvl[l-1].w_p[(2*n+1)*(l-1) +: (l-1)];
        assign w_pl = g_lvl[l-1].w_p[(2*n)*(l-1) +: (l-1)];
        assign w_v[n]         = w_vh | w_vl;
        assign w_p[n*l +: l]  = w_vh ? {1'b0, w_ph} : {1'b1, w_pl};
      end
    end
  end

  assign w_v_top = g_lvl[P_BITS].w_v[0];
  assign w_p_top = g_lvl[P_BITS].w_p[P_BITS-1:0];

  // An all-zero word has no representable count, so p is pinned to 0 there.
  always_ff @(posedge clk) begin
    if (rst) begin
      p <= '0;
      v <= 1'b0;
    end else begin
      p <= w_v_top ? w_p_top : '0;
      v <= w_v_top;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lzd_8.sv
`default_nettype none
// Self-checking bench for lzd_8: directed cases plus random words against a count model.
module tb_lzd_8;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [4:0]  p;
  logic        v;

  int n_checks = 0;
  int n_errors = 0;

  lzd_8 #(.LZD_BITS(32), .P_BITS(5)) u_dut (
    .clk(clk),
    .rst(rst),
    .a  (a),
    .p  (p),
    .v  (v)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Reference: shift left until the top bit is set; the number of shifts is the count.
  function automatic int ref_count(input logic [31:0] x);
    logic [31:0] t;
    int          c;
    t = x;
    c = 0;
    if (x == 32'h0) return 0;
    while (t[31] == 1'b0) begin
      t = t << 1;
      c = c + 1;
    end
    return c;
  endfunction

  // Drive one word (and rst) before an edge, then check the registered result after it.
  task automatic step(input string tag, input logic [31:0] word, input logic r);
    @(negedge clk);
    a   = word;
    rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      chk({tag, "_p"}, {27'd0, p}, 32'd0);
      chk({tag, "_v"}, {31'd0, v}, 32'd0);
    end else begin
      chk({tag, "_p"}, {27'd0, p}, ref_count(word));
      chk({tag, "_v"}, {31'd0, v}, (word != 32'h0) ? 32'd1 : 32'd0);
    end
  endtask

  // Directed check where the expected count is written out literally.
  task automatic step_lit(input string tag, input logic [31:0] word, input int exp_p);
    step(tag, word, 1'b0);
    chk({tag, "_lit"}, {27'd0, p}, exp_p);
  endtask

  initial begin
    logic [31:0] w;
    rst = 1'b1;
    a   = 32'hFFFF_FFFF;

    step("rst0", 32'hFFFF_FFFF, 1'b1);
    step("rst1", 32'hFFFF_FFFF, 1'b1);
    step_lit("rel", 32'hFFFF_FFFF, 0);

    step_lit("zero", 32'h0, 0);
    step_lit("w1", 32'h1, 31);
    step_lit("w2", 32'h2, 30);
    step_lit("w4", 32'h4, 29);
    step_lit("w8a", 32'h8, 28);
    step_lit("w8b", 32'h8, 28);
    step_lit("w10", 32'h10, 27);
    step_lit("w100", 32'h100, 23);

    step_lit("l21", 32'h21, 26);
    step_lit("l42", 32'h42, 25);
    step_lit("l84", 32'h84, 24);
    step_lit("l208", 32'h208, 22);
    step_lit("l8001", 32'h8000_0001, 0);
    step_lit("lfff", 32'hFFFF_FFFF, 0);

    step_lit("b15", 32'h0000_8000, 16);
    step_lit("b16", 32'h0001_0000, 15);
    step_lit("b23", 32'h0080_0000, 8);
    step_lit("b24", 32'h0100_0000, 7);
    step_lit("b30", 32'h4000_0000, 1);

    step_lit("bb0", 32'h1, 31);
    step_lit("bb1", 32'h8000_0000, 0);
    step_lit("bb2", 32'h0, 0);

    step_lit("pre", 32'h1, 31);
    step("rstmid", 32'h8000_0000, 1'b1);
    step_lit("post", 32'h0, 0);
    step_lit("post2", 32'h0000_0400, 21);

    for (int i = 0; i < 32; i++) begin
      w = 32'h1 << i;
      step("single", w, 1'b0);
    end

    for (int i = 0; i < 1000; i++) begin
      w = $urandom;
      w = w >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) w = 32'h0;
      step("rand", w, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
